dft_compute_fadd_arbiter: RTL
=============================

DFT_COMPUTE_FADD_ARBITER -- requirements
Module: dft_compute_fadd_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one pipelined float adder (range 2..8).
REQ-002 Parameter LAT, default 1: adder latency in aclk cycles from operand drive to add_x valid (range 1..4).
REQ-003 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester operand-pair valid.
REQ-006 req_ready  out  NREQ  one-hot grant; pair accepted when req_valid[i] and req_ready[i] are both high.
REQ-007 req_a  in  32*NREQ  packed IEEE-754 single operand A; slice i is bits [32i+31:32i].
REQ-008 req_b  in  32*NREQ  packed IEEE-754 single operand B, same packing.
REQ-009 add_a_sign/add_a_exp/add_a_man  out  1/8/23  operand A fields to adder.
REQ-010 add_b_sign/add_b_exp/add_b_man  out  1/8/23  operand B fields to adder.
REQ-011 add_x  in  32  adder result.
REQ-012 add_stall  out  1  adder pipeline freeze (drives adder astall).
REQ-013 rsp_valid  out  1  result valid.
REQ-014 rsp_id  out  clog2(NREQ)  index of the requester owning the result.
REQ-015 rsp_x  out  32  result, equal to add_x.
REQ-016 rsp_ready  in  1  downstream accepts result.

Function
REQ-017 Tag pipeline: LAT stages, each holding {valid, id}; stage 0 loads the issue, stage LAT-1 is the output stage.
REQ-018 rsp_valid = valid of stage LAT-1; rsp_id = id of stage LAT-1; rsp_x = add_x, combinational.
REQ-019 add_stall = rsp_valid AND NOT rsp_ready.
REQ-020 While add_stall is high: tag pipeline, RR pointer and grants frozen; req_ready all zero.
REQ-021 While add_stall is low: tag pipeline shifts one stage per cycle; stage 0 loads {issue, grant id}; an idle cycle inserts valid=0.
REQ-022 Grant is combinational: first requester with req_valid high, searching from ptr upward with wrap NREQ-1 -> 0; at most one req_ready bit high.
REQ-023 On issue, add_a/add_b fields are the granted requester's req_a/req_b slices in the same cycle; with no issue, they are driven to zero.
REQ-024 On issue, ptr <= (granted id + 1) mod NREQ; otherwise ptr holds.
REQ-025 Sustained throughput: one issue per cycle with rsp_ready held high; result for an issue in cycle t appears in cycle t+LAT.
REQ-026 Results are returned in issue order; none are dropped or duplicated across any stall pattern.
REQ-027 Request deasserted before grant: no issue and no state change for that requester.

Reset
REQ-028 While aresetn is low at the edge: all tag valids <= 0 and ptr <= 0; next cycle rsp_valid=0, add_stall=0.
REQ-029 req_ready is forced to zero in any cycle aresetn is low.
REQ-030 Reset mid-operation discards in-flight results; the adder's unreset data register is masked by the tag valids.

Configuration
REQ-031 Macro DFT_COMPUTE_FADD_ARB_PRIO0_EN defined: requester 0 wins whenever req_valid[0] is high; the others are round-robin as above, and ptr is unchanged on a requester-0 grant.
REQ-032 Macro undefined: pure round-robin per REQ-022 and REQ-024.

Verification
REQ-033 LAT=1, req0 A=0x3F800000 B=0x40000000 with rsp_ready=1 -> issue cycle t; at t+1, rsp_valid=1, rsp_id=0, rsp_x=0x40400000.
REQ-034 All 4 requesters valid continuously, macro undefined -> grants 0,1,2,3,0,... one per cycle, rsp_id sequence identical LAT cycles later.
REQ-035 rsp_ready=0 for 3 cycles with a valid result -> add_stall=1, req_ready=0, rsp_x/rsp_id held; release -> no loss, order kept.
REQ-036 Macro defined, req0 and req2 valid continuously -> req0 granted every cycle; drop req0 -> req2 granted next cycle.
REQ-037 LAT=2, two issues in flight, aresetn low one cycle -> rsp_valid=0 for the next 2 cycles; a fresh issue returns normally.
REQ-038 Only req3 valid with ptr=0 -> req3 granted (wrap search); ptr becomes 0.

Source files
------------

// File: rtl/dft_compute_fadd_arbiter.sv
// Round-robin arbiter sharing one pipelined float adder among NREQ requesters, with an in-order tag pipeline.
// Optional build macro DFT_COMPUTE_FADD_ARB_PRIO0_EN gives requester 0 absolute priority over the round-robin.
module dft_compute_fadd_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [32*NREQ-1:0]        req_a,
  input  logic [32*NREQ-1:0]        req_b,
  output logic                      add_a_sign,
  output logic [7:0]                add_a_exp,
  output logic [22:0]               add_a_man,
  output logic                      add_b_sign,
  output logic [7:0]                add_b_exp,
  output logic [22:0]               add_b_man,
  input  logic [31:0]               add_x,
  output logic                      add_stall,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [31:0]               rsp_x,
  input  logic                      rsp_ready
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;
  logic [LAT-1:0] tag_valid_reg;
  logic [IDW-1:0] tag_id_reg [LAT];

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           issue;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;

  assign rsp_valid = tag_valid_reg[LAT-1];
  assign rsp_id    = tag_id_reg[LAT-1];
  assign rsp_x     = add_x;
  assign add_stall = rsp_valid & ~rsp_ready;

  // First valid requester searching upward from ptr, wrapping to 0.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
`ifdef DFT_COMPUTE_FADD_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt_found = 1'b1;
      gnt_id    = '0;
    end
`endif
  end

  assign issue = gnt_found & ~add_stall & aresetn;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = issue && (gnt_id == IDW'(gi));
    end
  endgenerate

  // Operands are zero whenever nothing issues so the adder sees a quiet bus.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (gnt_id == IDW'(i))) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  assign add_a_sign = sel_a[31];
  assign add_a_exp  = sel_a[30:23];
  assign add_a_man  = sel_a[22:0];
  assign add_b_sign = sel_b[31];
  assign add_b_exp  = sel_b[30:23];
  assign add_b_man  = sel_b[22:0];

  always_comb begin
    ptr_next = ptr_reg;
    if (issue) begin
`ifdef DFT_COMPUTE_FADD_ARB_PRIO0_EN
      if (gnt_id != '0)
        ptr_next = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
`else
      ptr_next = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
`endif
    end
  end

  // Tag ids are left unreset; the valids alone decide what is presented.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_reg       <= '0;
      tag_valid_reg <= '0;
    end else if (!add_stall) begin
      ptr_reg          <= ptr_next;
      tag_valid_reg[0] <= issue;
      tag_id_reg[0]    <= gnt_id;
      for (int s = 1; s < LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

endmodule
